// File: rtl/cvp14_mem_responder_if.sv
// Processor-to-memory bus between the core (master) and the memory responder (slave).
interface cvp14_mem_responder_if;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        RdValid;
  logic        BusErr;
  logic [4:0]  BurstLen;

  modport master (
    output Addr, RD, WR, V, DataWr,
    input  DataRd, RdValid, BusErr, BurstLen
  );

  modport slave (
    input  Addr, RD, WR, V, DataWr,
    output DataRd, RdValid, BusErr, BurstLen
  );
endinterface

// File: rtl/cvp14_mem_responder.sv
// Word-addressed memory responder: 1-cycle read latency, vector burst tracking
// and a registered one-cycle BusErr pulse for protocol violations.
module cvp14_mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_BURST = 16
) (
  input logic Clk1,
  input logic Reset,
  cvp14_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam logic [4:0]  BURST_MAX = 5'(MAX_BURST);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VREAD  = 2'd1;
  localparam logic [1:0] VWRITE = 2'd2;

  logic [15:0] mem [DEPTH];

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  dir_state;
  logic [15:0] expected;
  logic [15:0] expected_nxt;
  logic [4:0]  burst_len;
  logic [4:0]  burst_len_nxt;

  logic [15:0] data_rd;
  logic        rd_valid;
  logic        bus_err;

  logic                 rd_req;
  logic                 wr_req;
  logic                 conflict;
  logic                 in_range;
  logic                 access_err;
  logic                 burst_err;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] word_addr;

  assign rd_req     = bus.RD & ~bus.WR;
  assign wr_req     = bus.WR & ~bus.RD;
  assign conflict   = bus.RD & bus.WR;
  assign in_range   = (bus.Addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign word_addr  = bus.Addr[ADDR_BITS-1:0];
  assign mem_we     = wr_req & in_range;
  assign access_err = conflict | ((rd_req | wr_req) & ~in_range);

  // Burst tracker: any V access that is not the next sequential word in the
  // same direction restarts the burst; a restart from a live burst is an error.
  always_comb begin
    state_nxt     = state;
    expected_nxt  = expected;
    burst_len_nxt = burst_len;
    burst_err     = 1'b0;
    dir_state     = rd_req ? VREAD : VWRITE;
    if (conflict || !bus.V || !(rd_req || wr_req)) begin
      state_nxt = IDLE;
    end else begin
      state_nxt    = dir_state;
      expected_nxt = bus.Addr + 16'd1;
      if (state == dir_state && bus.Addr == expected) begin
        if (burst_len == BURST_MAX) begin
          burst_err = 1'b1;
        end else begin
          burst_len_nxt = burst_len + 5'd1;
        end
      end else begin
        burst_err     = (state != IDLE);
        burst_len_nxt = 5'd1;
      end
    end
  end

  // Memory contents survive reset; a write sampled while reset is low is dropped.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
    end else if (mem_we) begin
      mem[word_addr] <= bus.DataWr;
    end
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      expected  <= 16'h0000;
      burst_len <= 5'd0;
      data_rd   <= 16'h0000;
      rd_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      burst_len <= burst_len_nxt;
      bus_err   <= access_err | burst_err;
      rd_valid  <= rd_req;
      if (rd_req) begin
        data_rd <= in_range ? mem[word_addr] : 16'h0000;
      end
    end
  end

  assign bus.DataRd   = data_rd;
  assign bus.RdValid  = rd_valid;
  assign bus.BusErr   = bus_err;
  assign bus.BurstLen = burst_len;

endmodule
